// File: rtl/tmds_channel_decoder.sv
// TMDS receive lane: finds the 10-bit word boundary from runs of control tokens,
// slides the bit offset until lock, and decodes every aligned word to data/ctrl/de.
module tmds_channel_decoder #(
  parameter int LOCK_COUNT     = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOSS_TIMEOUT   = 2048
) (
  input  logic       pixclk_i,
  input  logic       rst_n_i,
  input  logic [9:0] raw_word_i,
  output logic [7:0] data_o,
  output logic [1:0] ctrl_o,
  output logic       de_o,
  output logic       locked_o,
  output logic [3:0] offset_o
);

  localparam int RUN_W   = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam int TMO_MAX = (LOSS_TIMEOUT > SEARCH_TIMEOUT) ? LOSS_TIMEOUT : SEARCH_TIMEOUT;
  localparam int TMO_W   = (TMO_MAX > 1) ? $clog2(TMO_MAX) : 1;

  localparam logic [RUN_W-1:0] RUN_LAST    = RUN_W'(LOCK_COUNT - 1);
  localparam logic [TMO_W-1:0] SEARCH_LAST = TMO_W'(SEARCH_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] LOSS_LAST   = TMO_W'(LOSS_TIMEOUT - 1);

  typedef enum logic {SEARCH, LOCKED} state_e;

  state_e           state_q, state_d;
  logic [3:0]       offset_q, offset_d, offset_next;
  logic [RUN_W-1:0] run_q, run_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [1:0]       flush_q, flush_d;

  logic [9:0]  prev_q;
  logic [9:0]  aligned_q;
  logic [9:0]  aligned_d;
  logic [19:0] window;
  logic [7:0]  data_q;
  logic [1:0]  ctrl_q;
  logic        de_q;

  logic        is_tok;
  logic [1:0]  tok_cd;
  logic [7:0]  d_word;
  logic [6:0]  chain;
  logic [7:0]  dec_byte;

  // Older word sits in the low half, so the earliest serial bit is window[0].
  assign window    = {raw_word_i, prev_q};
  assign aligned_d = 10'(window >> offset_q);

  always_comb begin
    is_tok = 1'b1;
    tok_cd = 2'b00;
    case (aligned_q)
      10'b1101010100: tok_cd = 2'b00;
      10'b0010101011: tok_cd = 2'b01;
      10'b0101010100: tok_cd = 2'b10;
      10'b1010101011: tok_cd = 2'b11;
      default:        is_tok = 1'b0;
    endcase
  end

  assign d_word   = aligned_q[9] ? ~aligned_q[7:0] : aligned_q[7:0];
  assign chain    = d_word[7:1] ^ d_word[6:0];
  assign dec_byte = {aligned_q[8] ? chain : ~chain, d_word[0]};

  always_ff @(posedge pixclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prev_q    <= '0;
      aligned_q <= '0;
      data_q    <= '0;
      ctrl_q    <= '0;
      de_q      <= 1'b0;
    end else begin
      prev_q    <= raw_word_i;
      aligned_q <= aligned_d;
      de_q      <= ~is_tok;
      if (is_tok) begin
        ctrl_q <= tok_cd;
      end else begin
        data_q <= dec_byte;
      end
    end
  end

  always_ff @(posedge pixclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= SEARCH;
      offset_q <= '0;
      run_q    <= '0;
      tmo_q    <= '0;
      flush_q  <= '0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      run_q    <= run_d;
      tmo_q    <= tmo_d;
      flush_q  <= flush_d;
    end
  end

  assign offset_next = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    run_d    = run_q;
    tmo_d    = tmo_q;
    flush_d  = flush_q;
    // aligned_q still reflects the old offset for two words after a slip.
    if (flush_q != 2'd0) begin
      flush_d = flush_q - 2'd1;
      run_d   = '0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        SEARCH: begin
          if (is_tok && (run_q >= RUN_LAST)) begin
            state_d = LOCKED;
            run_d   = '0;
            tmo_d   = '0;
          end else if (tmo_q >= SEARCH_LAST) begin
            offset_d = offset_next;
            run_d    = '0;
            tmo_d    = '0;
            flush_d  = 2'd2;
          end else begin
            run_d = is_tok ? run_q + 1'b1 : '0;
            tmo_d = tmo_q + 1'b1;
          end
        end
        LOCKED: begin
          run_d = '0;
          if (is_tok) begin
            tmo_d = '0;
          end else if (tmo_q >= LOSS_LAST) begin
            state_d  = SEARCH;
            offset_d = offset_next;
            tmo_d    = '0;
            flush_d  = 2'd2;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  assign data_o   = data_q;
  assign ctrl_o   = ctrl_q;
  assign de_o     = de_q;
  assign locked_o = (state_q == LOCKED);
  assign offset_o = offset_q;

endmodule
